// File: rtl/operacion_seq.sv
// Sequential polynomial operation unit: X*X-Y, X+Y*X, X*Y, X*X+Y on W-bit operands,
// using an iterative shift-add multiplier, with valid/ready handshakes on both sides.
module operacion_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  input  logic [1:0]     C,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           neg
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MULT, ADJ, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]     c_q, c_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;

  logic [2*W-1:0] x_ext, y_ext;
  logic [W-1:0]   mplr;
  logic [2*W:0]   diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    x_ext   = {{W{1'b0}}, x_q};
    y_ext   = {{W{1'b0}}, y_q};
    // Modes 00/11 square X; modes 01/10 multiply X by Y.
    mplr    = (c_q == 2'b00 || c_q == 2'b11) ? x_q : y_q;
    // Extra top bit carries the borrow for X*X-Y.
    diff    = {1'b0, acc_q} - {1'b0, y_ext};

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          c_d     = C;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (mplr[cnt_q]) acc_d = acc_q + (x_ext << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = ADJ;
      end
      ADJ: begin
        neg_d = 1'b0;
        unique case (c_q)
          2'b00: begin
            res_d = diff[2*W-1:0];
            neg_d = diff[2*W];
          end
          2'b01:   res_d = acc_q + x_ext;
          2'b10:   res_d = acc_q;
          default: res_d = acc_q + y_ext;
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_operacion_seq.sv
// Bench for operacion_seq: directed scenarios on W=8 plus randomized operands on
// W=4, 8 and 16 instances, compared against an arithmetic reference model.
module tb_operacion_seq;

  logic        clk;
  logic        rst_n;
  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] xs   [3];
  logic [15:0] ys   [3];
  logic [1:0]  cs   [3];

  logic        ir4, ir8, ir16, ov4, ov8, ov16, ng4, ng8, ng16;
  logic [7:0]  r4;
  logic [15:0] r8;
  logic [31:0] r16;

  logic        ir_a [3];
  logic        ov_a [3];
  logic        ng_a [3];
  logic [31:0] rs_a [3];

  int nchk  = 0;
  int nfail = 0;

  assign ir_a[0] = ir4;  assign ir_a[1] = ir8;  assign ir_a[2] = ir16;
  assign ov_a[0] = ov4;  assign ov_a[1] = ov8;  assign ov_a[2] = ov16;
  assign ng_a[0] = ng4;  assign ng_a[1] = ng8;  assign ng_a[2] = ng16;
  assign rs_a[0] = {24'b0, r4};
  assign rs_a[1] = {16'b0, r8};
  assign rs_a[2] = r16;

  operacion_seq #(.W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4),
    .X(xs[0][3:0]), .Y(ys[0][3:0]), .C(cs[0]), .out_valid(ov4),
    .out_ready(ordy[0]), .res(r4), .neg(ng4));

  operacion_seq #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir8),
    .X(xs[1][7:0]), .Y(ys[1][7:0]), .C(cs[1]), .out_valid(ov8),
    .out_ready(ordy[1]), .res(r8), .neg(ng8));

  operacion_seq #(.W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir16),
    .X(xs[2]), .Y(ys[2]), .C(cs[2]), .out_valid(ov16),
    .out_ready(ordy[2]), .res(r16), .neg(ng16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the operation as plain integer arithmetic, reduced mod 2^(2w).
  function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                input logic [1:0] c, output logic [31:0] r, output logic n);
    longint unsigned xx = 64'(x);
    longint unsigned yy = 64'(y);
    longint unsigned t;
    longint unsigned m = (64'd1 << (2 * w)) - 64'd1;
    case (c)
      2'd0:    t = xx * xx - yy;
      2'd1:    t = xx + yy * xx;
      2'd2:    t = xx * yy;
      default: t = xx * xx + yy;
    endcase
    n = (c == 2'd0) && (xx * xx < yy);
    r = 32'(t & m);
  endfunction

  function automatic int wof(input int i);
    return 4 << i;
  endfunction

  task automatic wait_valid(input int i, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ov_a[i] !== 1'b1 && n < 64);
  endtask

  task automatic do_op(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic [1:0] c, input logic [31:0] er, input logic en,
                       input string tag);
    int n;
    ordy[i] = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(ir_a[i]), 64'd1);
    iv[i] = 1'b1; xs[i] = x; ys[i] = y; cs[i] = c;
    @(posedge clk); #1;
    iv[i] = 1'b0; xs[i] = 16'($urandom); ys[i] = 16'($urandom); cs[i] = 2'($urandom);
    chk({tag, " accepted"}, 64'(ir_a[i]), 64'd0);
    wait_valid(i, n);
    chk({tag, " latency"}, 64'(n), 64'(wof(i) + 1));
    chk({tag, " res"}, 64'(rs_a[i]), 64'(er));
    chk({tag, " neg"}, 64'(ng_a[i]), 64'(en));
    @(posedge clk); #1;
    chk({tag, " out_valid clear"}, 64'(ov_a[i]), 64'd0);
    chk({tag, " back to idle"}, 64'(ir_a[i]), 64'd1);
  endtask

  task automatic rand_run(input int i);
    int w = wof(i);
    logic [15:0] mask = 16'((32'd1 << w) - 32'd1);
    logic [15:0] x, y;
    logic [31:0] er;
    logic en;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 300; k++) begin
        x = 16'($urandom) & mask;
        y = 16'($urandom) & mask;
        if (k == 0) begin x = mask; y = mask; end
        if (k == 1) begin x = '0; y = mask; end
        model(w, x, y, 2'(c), er, en);
        do_op(i, x, y, 2'(c), er, en, $sformatf("rand w%0d c%0d", w, c));
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] er;
    logic en;

    // Reset with garbage on the inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b1; ordy[i] = 1'($urandom);
      xs[i] = 16'($urandom); ys[i] = 16'($urandom); cs[i] = 2'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset res %0d", i), 64'(rs_a[i]), 64'd0);
      chk($sformatf("reset neg %0d", i), 64'(ng_a[i]), 64'd0);
      chk($sformatf("reset out_valid %0d", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("reset in_ready %0d", i), 64'(ir_a[i]), 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("idle res %0d", i), 64'(rs_a[i]), 64'd0);
      chk($sformatf("idle out_valid %0d", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("idle in_ready %0d", i), 64'(ir_a[i]), 64'd1);
    end

    // Mode sweep and extremes, W=8
    do_op(1, 16'd12, 16'd5, 2'b00, 32'd139, 1'b0, "sweep c00");
    do_op(1, 16'd12, 16'd5, 2'b01, 32'd72,  1'b0, "sweep c01");
    do_op(1, 16'd12, 16'd5, 2'b10, 32'd60,  1'b0, "sweep c10");
    do_op(1, 16'd12, 16'd5, 2'b11, 32'd149, 1'b0, "sweep c11");
    do_op(1, 16'd0,   16'd5,   2'b00, 32'h0000FFFB, 1'b1, "borrow");
    do_op(1, 16'd255, 16'd255, 2'b01, 32'h0000FF00, 1'b0, "max c01");

    // Reset during the 4th MULT cycle
    @(negedge clk);
    iv[1] = 1'b1; xs[1] = 16'd200; ys[1] = 16'd100; cs[1] = 2'b10;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset in_ready", 64'(ir_a[1]), 64'd1);
    chk("midreset out_valid", 64'(ov_a[1]), 64'd0);
    chk("midreset res", 64'(rs_a[1]), 64'd0);
    chk("midreset neg", 64'(ng_a[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 16'd7, 16'd6, 2'b10, 32'd42, 1'b0, "after reset");

    // Backpressure: result held, new requests ignored while DONE
    ordy[1] = 1'b0;
    @(negedge clk);
    iv[1] = 1'b1; xs[1] = 16'd12; ys[1] = 16'd5; cs[1] = 2'b11;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    wait_valid(1, n);
    chk("bp latency", 64'(n), 64'd9);
    chk("bp res", 64'(rs_a[1]), 64'd149);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      iv[1] = 1'($urandom); xs[1] = 16'($urandom); ys[1] = 16'($urandom); cs[1] = 2'($urandom);
      @(posedge clk); #1;
      chk("bp held out_valid", 64'(ov_a[1]), 64'd1);
      chk("bp held res", 64'(rs_a[1]), 64'd149);
      chk("bp held neg", 64'(ng_a[1]), 64'd0);
      chk("bp in_ready low", 64'(ir_a[1]), 64'd0);
    end
    @(negedge clk);
    ordy[1] = 1'b1; iv[1] = 1'b1; xs[1] = 16'd3; ys[1] = 16'd9; cs[1] = 2'b00;
    @(posedge clk); #1;
    chk("bp release out_valid", 64'(ov_a[1]), 64'd0);
    chk("bp release in_ready", 64'(ir_a[1]), 64'd1);
    chk("bp release res kept", 64'(rs_a[1]), 64'd149);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    chk("bp next accept", 64'(ir_a[1]), 64'd0);
    wait_valid(1, n);
    chk("exact zero latency", 64'(n), 64'd9);
    chk("exact zero res", 64'(rs_a[1]), 64'd0);
    chk("exact zero neg", 64'(ng_a[1]), 64'd0);
    @(posedge clk); #1;
    chk("exact zero out_valid clear", 64'(ov_a[1]), 64'd0);

    // Width 16 extreme
    do_op(2, 16'hFFFF, 16'hFFFF, 2'b10, 32'hFFFE0001, 1'b0, "w16 max");

    // Sanity of the reference model on one known point per width
    model(4, 16'd15, 16'd15, 2'b11, er, en);
    do_op(0, 16'd15, 16'd15, 2'b11, er, en, "w4 max c11");

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
